stack_alu: RTL and testbench
============================

Name: stack_alu

Overview:
- Execute stage directly downstream of the stack register file.
- Consumes top-of-stack (a) and next-of-stack (b) on an issue strobe and returns one result word, which control pushes back onto the stack.
- Simple ops complete in one cycle. MUL/DIVU/REMU run iteratively over DBITS cycles, with busy used to stall the pipeline.

Parameters:
DBITS, 32, operand/result width; power of two, 8..64.
OPBITS, 4, opcode width.

Ports:
clk  input  1  rising-edge clock
rst  input  1  asynchronous reset, active-low
start  input  1  issue strobe; operation accepted only when busy=0
op  input  OPBITS  operation code, sampled with start
a  input  DBITS  top of stack (stack dout1)
b  input  DBITS  next of stack (stack dout2)
busy  output  1  high while an iterative op is in progress
done  output  1  one-cycle pulse; result valid
result  output  DBITS  result word; held until next done
dz  output  1  divide-by-zero flag; valid with done, held
illegal  output  1  unknown opcode flag; valid with done, held

Behaviour:
- Reset (rst=0, asynchronous): state IDLE; busy, done, dz, illegal and result all 0; iteration counter 0; latched operands 0. Reset mid-iteration aborts the op with no done pulse.
- Opcodes (b is the left operand):
  - 0 ADD: b+a
  - 1 SUB: b-a
  - 2 AND
  - 3 OR
  - 4 XOR
  - 5 SHL: b<<a[log2(DBITS)-1:0]
  - 6 SHR: logical
  - 7 SLT: signed, result 1 or 0
  - 8 MUL: low DBITS of the product
  - 9 DIVU: unsigned quotient
  - 10 REMU: unsigned remainder
  - 11..15: illegal
- Arithmetic wraps modulo 2^DBITS. No overflow flag.
- FSM states: IDLE, MUL, DIV.
- IDLE, start=1, op in 0..7 or illegal: result registered at the next edge, done=1 for that cycle, stay IDLE. Latency 1.
- Illegal op: result=0, illegal=1, dz=0.
- IDLE, start=1, op 8: latch a/b, counter=DBITS, busy=1, go to MUL. Shift-add runs one multiplier bit per cycle.
- IDLE, start=1, op 9/10: if a==0, behave as single-cycle with dz=1; DIVU gives all ones, REMU gives b. Otherwise latch operands, busy=1, go to DIV. Restoring division runs one quotient bit per cycle.
- MUL/DIV: counter decrements each cycle. On the cycle counter reaches 0:
  - result, dz=0, illegal=0 registered;
  - done=1 for one cycle;
  - busy=0 and state returns to IDLE at the same edge.
- Iterative latency: DBITS+1 cycles from start edge to done (33 at default).
- start while busy=1: ignored, no state change. The upstream controller must hold the op.
- start on the same cycle done=1: accepted, since the FSM is already IDLE. Back-to-back issue is legal.
- Operands are latched at accept. Changes on a/b during iteration have no effect.
- done never asserts twice for a single accepted op. dz and illegal are cleared on every done that does not set them.

Decomposition:
- Package stack_alu_pkg:
  - opcode localparams OP_ADD..OP_REMU;
  - state encoding IDLE/MUL/DIV;
  - function for counter width $clog2(DBITS)+1.
- One sub-module, stack_alu_iter: shared shift register, accumulator and counter datapath for MUL/DIV, with its own start/done.
- Single-cycle ops stay in the top-level combinational mux.

Test Plan:
- Reset then start with op=0, b=7, a=5 -> done next cycle, result=12, busy never high; then op=1, b=5, a=7 -> result=0xFFFFFFFE.
- op=7, b=0xFFFFFFFF, a=1 -> result=1; op=5, b=1, a=31 -> result=0x80000000; op=13 -> result=0, illegal=1.
- op=8, b=0x00012345, a=0x00000100 -> busy for 32 cycles, done at cycle 33, result=0x01234500; start pulses mid-op are ignored.
- op=9, b=100, a=7 -> result=14; op=10, same operands, issued on the done cycle -> result=2 after 33 more cycles.
- op=9, b=55, a=0 -> done after 1 cycle, result=0xFFFFFFFF, dz=1; op=10 -> result=55, dz=1.
- Start op=8, drive rst=0 at cycle 10 asynchronously -> busy, done and result go 0 immediately. After release, op=0, b=1, a=1 -> result=2.

Source files
------------

// File: rtl/stack_alu_pkg.sv
// rtl/stack_alu_pkg.sv - shared opcodes, FSM encoding and sizing helpers for stack_alu
//
// Purpose: common definitions imported by stack_alu and stack_alu_iter.
// Contents:
//   OP_ADD..OP_REMU  opcode values (11..15 are illegal)
//   state_e          top-level FSM encoding (IDLE / MUL / DIV)
//   cnt_width()      iteration counter width for a given data width

package stack_alu_pkg;

  localparam logic [3:0] OP_ADD  = 4'd0;
  localparam logic [3:0] OP_SUB  = 4'd1;
  localparam logic [3:0] OP_AND  = 4'd2;
  localparam logic [3:0] OP_OR   = 4'd3;
  localparam logic [3:0] OP_XOR  = 4'd4;
  localparam logic [3:0] OP_SHL  = 4'd5;
  localparam logic [3:0] OP_SHR  = 4'd6;
  localparam logic [3:0] OP_SLT  = 4'd7;
  localparam logic [3:0] OP_MUL  = 4'd8;
  localparam logic [3:0] OP_DIVU = 4'd9;
  localparam logic [3:0] OP_REMU = 4'd10;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_MUL  = 2'd1,
    ST_DIV  = 2'd2
  } state_e;

  // Counter must hold the value DBITS itself, hence one bit above log2.
  function automatic int cnt_width(input int dbits);
    return $clog2(dbits) + 1;
  endfunction

endpackage

// File: rtl/stack_alu_iter.sv
// rtl/stack_alu_iter.sv - iterative shift-add multiply / restoring divide datapath
//
// Purpose: one-bit-per-cycle MUL, DIVU and REMU sharing a single shift
// register, accumulator and down-counter.
// Ports:
//   clk, rst       clock, asynchronous active-low reset
//   start_i        load operands and begin DBITS iterations
//   is_div_i       1: divide (b / a), 0: multiply (b * a); sampled with start_i
//   want_rem_i     for divide, return remainder instead of quotient
//   a_i, b_i       operands (a = divisor / multiplier, b = dividend / multiplicand)
//   done_o         high in the cycle whose edge performs the final iteration
//   result_o       final result, valid while done_o is high

module stack_alu_iter
  import stack_alu_pkg::*;
#(
  parameter int DBITS = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start_i,
  input  logic             is_div_i,
  input  logic             want_rem_i,
  input  logic [DBITS-1:0] a_i,
  input  logic [DBITS-1:0] b_i,
  output logic             done_o,
  output logic [DBITS-1:0] result_o
);

  localparam int CW = cnt_width(DBITS);

  logic [CW-1:0]    cnt_q,      cnt_d;
  logic [DBITS-1:0] sr_q,       sr_d;
  logic [DBITS-1:0] acc_q,      acc_d;
  logic [DBITS-1:0] opnd_q,     opnd_d;
  logic             is_div_q,   is_div_d;
  logic             want_rem_q, want_rem_d;

  logic [DBITS:0]   mul_sum;
  logic [DBITS:0]   rem_shift;
  logic [DBITS-1:0] rem_diff;
  logic             fits;
  logic [DBITS-1:0] sr_step;
  logic [DBITS-1:0] acc_step;

  always_comb begin
    // Multiply: {acc, sr} is the running product; sr starts as the multiplier
    // and is shifted out LSB first while the product's low half shifts in.
    mul_sum   = {1'b0, acc_q} + {1'b0, (sr_q[0] ? opnd_q : {DBITS{1'b0}})};

    // Divide: acc is the partial remainder, sr the dividend that shifts out
    // MSB first while quotient bits shift in at the bottom.
    rem_shift = {acc_q, sr_q[DBITS-1]};
    fits      = (rem_shift >= {1'b0, opnd_q});
    // When fits, the true difference is below the divisor so the low DBITS
    // bits are exact.
    rem_diff  = rem_shift[DBITS-1:0] - opnd_q;

    if (is_div_q) begin
      acc_step = fits ? rem_diff : rem_shift[DBITS-1:0];
      sr_step  = {sr_q[DBITS-2:0], fits};
    end else begin
      acc_step = mul_sum[DBITS:1];
      sr_step  = {mul_sum[0], sr_q[DBITS-1:1]};
    end

    cnt_d      = cnt_q;
    sr_d       = sr_q;
    acc_d      = acc_q;
    opnd_d     = opnd_q;
    is_div_d   = is_div_q;
    want_rem_d = want_rem_q;

    if (start_i) begin
      cnt_d      = CW'(DBITS);
      acc_d      = '0;
      sr_d       = is_div_i ? b_i : a_i;
      opnd_d     = is_div_i ? a_i : b_i;
      is_div_d   = is_div_i;
      want_rem_d = want_rem_i;
    end else if (cnt_q != '0) begin
      cnt_d = cnt_q - CW'(1);
      sr_d  = sr_step;
      acc_d = acc_step;
    end

    done_o   = (cnt_q == CW'(1));
    result_o = (is_div_q && want_rem_q) ? acc_step : sr_step;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_q      <= '0;
      sr_q       <= '0;
      acc_q      <= '0;
      opnd_q     <= '0;
      is_div_q   <= 1'b0;
      want_rem_q <= 1'b0;
    end else begin
      cnt_q      <= cnt_d;
      sr_q       <= sr_d;
      acc_q      <= acc_d;
      opnd_q     <= opnd_d;
      is_div_q   <= is_div_d;
      want_rem_q <= want_rem_d;
    end
  end

endmodule

// File: rtl/stack_alu.sv
// rtl/stack_alu.sv - stack machine execute stage: single-cycle ALU plus iterative MUL/DIV
//
// Purpose: consumes top-of-stack (a) and next-of-stack (b) on start and
// returns one result word with a done pulse.
// Ports:
//   clk      rising-edge clock
//   rst      asynchronous reset, active-low
//   start    issue strobe, accepted only while busy=0
//   op       opcode (b is the left operand)
//   a, b     top / next of stack
//   busy     iterative op in progress
//   done     one-cycle result-valid pulse
//   result   result word, held until the next done
//   dz       divide-by-zero flag, valid with done, held
//   illegal  unknown opcode flag, valid with done, held

module stack_alu
  import stack_alu_pkg::*;
#(
  parameter int DBITS  = 32,
  parameter int OPBITS = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [OPBITS-1:0] op,
  input  logic [DBITS-1:0]  a,
  input  logic [DBITS-1:0]  b,
  output logic              busy,
  output logic              done,
  output logic [DBITS-1:0]  result,
  output logic              dz,
  output logic              illegal
);

  localparam int SHW = $clog2(DBITS);

  state_e           state_q,   state_d;
  logic [DBITS-1:0] result_q,  result_d;
  logic             done_q,    done_d;
  logic             dz_q,      dz_d;
  logic             illegal_q, illegal_d;

  logic             iter_start;
  logic             iter_done;
  logic [DBITS-1:0] iter_result;
  logic             is_div;
  logic             want_rem;
  logic [DBITS-1:0] simple_res;

  assign is_div   = (op != OPBITS'(OP_MUL));
  assign want_rem = (op == OPBITS'(OP_REMU));

  always_comb begin
    simple_res = '0;
    case (op)
      OPBITS'(OP_ADD): simple_res = b + a;
      OPBITS'(OP_SUB): simple_res = b - a;
      OPBITS'(OP_AND): simple_res = b & a;
      OPBITS'(OP_OR):  simple_res = b | a;
      OPBITS'(OP_XOR): simple_res = b ^ a;
      OPBITS'(OP_SHL): simple_res = b << a[SHW-1:0];
      OPBITS'(OP_SHR): simple_res = b >> a[SHW-1:0];
      OPBITS'(OP_SLT): simple_res = {{(DBITS-1){1'b0}}, ($signed(b) < $signed(a))};
      default:         simple_res = '0;
    endcase
  end

  always_comb begin
    state_d    = state_q;
    result_d   = result_q;
    done_d     = 1'b0;
    dz_d       = dz_q;
    illegal_d  = illegal_q;
    iter_start = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (start) begin
          case (op)
            OPBITS'(OP_ADD), OPBITS'(OP_SUB), OPBITS'(OP_AND), OPBITS'(OP_OR),
            OPBITS'(OP_XOR), OPBITS'(OP_SHL), OPBITS'(OP_SHR), OPBITS'(OP_SLT): begin
              result_d  = simple_res;
              dz_d      = 1'b0;
              illegal_d = 1'b0;
              done_d    = 1'b1;
            end
            OPBITS'(OP_MUL): begin
              iter_start = 1'b1;
              state_d    = ST_MUL;
            end
            OPBITS'(OP_DIVU), OPBITS'(OP_REMU): begin
              if (a == '0) begin
                // Divide by zero short-circuits: quotient saturates, remainder is the dividend.
                result_d  = want_rem ? b : {DBITS{1'b1}};
                dz_d      = 1'b1;
                illegal_d = 1'b0;
                done_d    = 1'b1;
              end else begin
                iter_start = 1'b1;
                state_d    = ST_DIV;
              end
            end
            default: begin
              result_d  = '0;
              dz_d      = 1'b0;
              illegal_d = 1'b1;
              done_d    = 1'b1;
            end
          endcase
        end
      end
      ST_MUL, ST_DIV: begin
        if (iter_done) begin
          result_d  = iter_result;
          dz_d      = 1'b0;
          illegal_d = 1'b0;
          done_d    = 1'b1;
          state_d   = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= ST_IDLE;
      result_q  <= '0;
      done_q    <= 1'b0;
      dz_q      <= 1'b0;
      illegal_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      result_q  <= result_d;
      done_q    <= done_d;
      dz_q      <= dz_d;
      illegal_q <= illegal_d;
    end
  end

  stack_alu_iter #(
    .DBITS (DBITS)
  ) u_iter (
    .clk        (clk),
    .rst        (rst),
    .start_i    (iter_start),
    .is_div_i   (is_div),
    .want_rem_i (want_rem),
    .a_i        (a),
    .b_i        (b),
    .done_o     (iter_done),
    .result_o   (iter_result)
  );

  assign busy    = (state_q != ST_IDLE);
  assign done    = done_q;
  assign result  = result_q;
  assign dz      = dz_q;
  assign illegal = illegal_q;

endmodule

// File: tb/tb_stack_alu.sv
// tb/tb_stack_alu.sv - scoreboard bench for stack_alu

module tb_stack_alu;

  logic        clk;
  logic        rst;
  logic        start;
  logic [3:0]  op;
  logic [31:0] a;
  logic [31:0] b;
  logic        busy;
  logic        done;
  logic [31:0] result;
  logic        dz;
  logic        illegal;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  typedef struct {
    logic [31:0] res;
    logic        dz;
    logic        ill;
    int          due;
  } exp_t;

  exp_t sb[$];

  stack_alu dut (
    .clk     (clk),
    .rst     (rst),
    .start   (start),
    .op      (op),
    .a       (a),
    .b       (b),
    .busy    (busy),
    .done    (done),
    .result  (result),
    .dz      (dz),
    .illegal (illegal)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  // Monitor: every done pulse must match the oldest outstanding expectation.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (rst && done) begin
        if (sb.size() == 0) begin
          total++;
          bad++;
          $display("FAIL unexpected_done: got done=1 want no done (result %0h)", result);
        end else begin
          e = sb.pop_front();
          chk("result", result, e.res);
          chk("dz", dz, e.dz);
          chk("illegal", illegal, e.ill);
          chk("done_cycle", cyc, e.due);
        end
      end
    end
  end

  // Drives the request for one capturing edge, then checks busy after accept.
  task automatic issue(input logic [3:0] o, input logic [31:0] av, input logic [31:0] bv,
                       input logic [31:0] er, input logic edz, input logic eill,
                       input int lat, input bit push);
    start = 1'b1;
    op    = o;
    a     = av;
    b     = bv;
    if (push) sb.push_back('{res: er, dz: edz, ill: eill, due: cyc + lat});
    @(posedge clk);
    #1;
    start = 1'b0;
    chk("busy_after_accept", busy, (lat > 1) ? 1 : 0);
  endtask

  task automatic drain();
    for (int i = 0; i < 100 && sb.size() > 0; i++) @(negedge clk);
    #1;
    chk("drain", sb.size(), 0);
  endtask

  task automatic go(input logic [3:0] o, input logic [31:0] av, input logic [31:0] bv,
                    input logic [31:0] er, input logic edz, input logic eill, input int lat);
    @(posedge clk);
    #1;
    issue(o, av, bv, er, edz, eill, lat, 1'b1);
    drain();
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    rst   = 1'b0;
    start = 1'b0;
    op    = 4'd0;
    a     = '0;
    b     = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_busy", busy, 0);
    chk("reset_done", done, 0);
    chk("reset_result", result, 0);
    chk("reset_dz", dz, 0);
    chk("reset_illegal", illegal, 0);
    @(negedge clk);
    rst = 1'b1;

    // Single-cycle ops, latency 1.
    go(4'd0,  32'd5,          32'd7,          32'd12,         1'b0, 1'b0, 1);
    go(4'd1,  32'd7,          32'd5,          32'hFFFF_FFFE,  1'b0, 1'b0, 1);
    go(4'd7,  32'd1,          32'hFFFF_FFFF,  32'd1,          1'b0, 1'b0, 1);
    go(4'd7,  32'hFFFF_FFFF,  32'd1,          32'd0,          1'b0, 1'b0, 1);
    go(4'd5,  32'd31,         32'd1,          32'h8000_0000,  1'b0, 1'b0, 1);
    go(4'd5,  32'd36,         32'd1,          32'h0000_0010,  1'b0, 1'b0, 1);
    go(4'd6,  32'd4,          32'h8000_0000,  32'h0800_0000,  1'b0, 1'b0, 1);
    go(4'd2,  32'h0000_FF00,  32'h0000_F0F0,  32'h0000_F000,  1'b0, 1'b0, 1);
    go(4'd3,  32'h0000_FF00,  32'h0000_F0F0,  32'h0000_FFF0,  1'b0, 1'b0, 1);
    go(4'd4,  32'h0000_FF00,  32'h0000_F0F0,  32'h0000_0FF0,  1'b0, 1'b0, 1);
    go(4'd13, 32'd3,          32'd9,          32'd0,          1'b0, 1'b1, 1);
    go(4'd15, 32'd3,          32'd9,          32'd0,          1'b0, 1'b1, 1);

    // MUL with ignored start pulses and operand churn mid-op.
    @(posedge clk);
    #1;
    issue(4'd8, 32'h0000_0100, 32'h0001_2345, 32'h0123_4500, 1'b0, 1'b0, 33, 1'b1);
    for (int i = 0; i < 3; i++) begin
      start = 1'b1;
      op    = 4'd0;
      a     = 32'd1;
      b     = 32'd1;
      @(posedge clk);
      #1;
      start = 1'b0;
      a     = 32'hDEAD_BEEF;
      @(posedge clk);
      #1;
    end
    chk("busy_mid_mul", busy, 1);
    drain();
    go(4'd8, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd1, 1'b0, 1'b0, 33);

    // DIVU then REMU issued on the done cycle.
    @(posedge clk);
    #1;
    issue(4'd9, 32'd7, 32'd100, 32'd14, 1'b0, 1'b0, 33, 1'b1);
    begin
      int n;
      n = 0;
      while (!done && n < 100) begin
        @(negedge clk);
        n++;
      end
      chk("div_done_seen", done, 1);
    end
    #1;
    issue(4'd10, 32'd7, 32'd100, 32'd2, 1'b0, 1'b0, 33, 1'b1);
    drain();
    go(4'd9,  32'd1,  32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 1'b0, 33);
    go(4'd10, 32'd10, 32'hFFFF_FFFF, 32'd5,         1'b0, 1'b0, 33);
    go(4'd9,  32'd100, 32'd7,        32'd0,         1'b0, 1'b0, 33);

    // Divide by zero is single-cycle; the following op clears dz.
    go(4'd9,  32'd0, 32'd55, 32'hFFFF_FFFF, 1'b1, 1'b0, 1);
    go(4'd10, 32'd0, 32'd55, 32'd55,        1'b1, 1'b0, 1);
    go(4'd0,  32'd2, 32'd3,  32'd5,         1'b0, 1'b0, 1);

    // Asynchronous reset mid-MUL aborts with no done.
    @(posedge clk);
    #1;
    issue(4'd8, 32'd3, 32'd4, 32'd12, 1'b0, 1'b0, 33, 1'b0);
    repeat (9) @(posedge clk);
    #3;
    rst = 1'b0;
    #1;
    chk("async_rst_busy", busy, 0);
    chk("async_rst_done", done, 0);
    chk("async_rst_result", result, 0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    go(4'd0, 32'd1, 32'd1, 32'd2, 1'b0, 1'b0, 1);

    repeat (40) @(posedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
